// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator input front end
package calc_pkg;

  localparam int OPW = 4;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } entry_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

endpackage

// File: rtl/calc_input_sequencer_if.sv
// rtl/calc_input_sequencer_if.sv - entry/display bundle from the input sequencer
interface calc_input_sequencer_if;
  import calc_pkg::*;

  logic [OPW-1:0] operand1;
  logic [OPW-1:0] operand2;
  logic [1:0]     op;
  logic           confirmed_operand1;
  logic           confirmed_operand2;
  logic           calc_start;
  logic           mode;

  modport master (
    output operand1, operand2, op, confirmed_operand1, confirmed_operand2, calc_start, mode
  );

  modport slave (
    input operand1, operand2, op, confirmed_operand1, confirmed_operand2, calc_start, mode
  );

endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer, stable-count debouncer and one-cycle press pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic          deb_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input agrees with the accepted level restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign pulse_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/calc_input_sequencer.sv
// rtl/calc_input_sequencer.sv - conditions board buttons and sequences operand/operator entry
module calc_input_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          BTNC,
  input  logic                          BTND,
  input  logic [OPW-1:0]                sw,
  input  logic [1:0]                    opsel,
  calc_input_sequencer_if.master        disp
);

  logic confirm_pulse;
  logic mode_pulse;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_confirm (
    .clk     (clk),
    .rst     (reset),
    .btn_i   (BTNC),
    .pulse_o (confirm_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk     (clk),
    .rst     (reset),
    .btn_i   (BTND),
    .pulse_o (mode_pulse)
  );

  entry_state_t   state_q, state_d;
  logic [OPW-1:0] operand1_q, operand1_d;
  logic [OPW-1:0] operand2_q, operand2_d;
  op_t            op_q, op_d;
  logic           calc_start_q, calc_start_d;
  logic           mode_q, mode_d;
  logic           conf1, conf2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (confirm_pulse) begin
      case (state_q)
        ENTER_A: state_d = ENTER_B;
        ENTER_B: state_d = SHOW;
        SHOW:    state_d = ENTER_A;
        default: state_d = ENTER_A;
      endcase
    end
  end

  // Confirm flags come straight from the state register so they never glitch.
  always_comb begin
    conf1 = 1'b0;
    conf2 = 1'b0;
    case (state_q)
      ENTER_B: conf1 = 1'b1;
      SHOW: begin
        conf1 = 1'b1;
        conf2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    operand1_d   = operand1_q;
    operand2_d   = operand2_q;
    op_d         = op_q;
    calc_start_d = 1'b0;
    mode_d       = mode_q ^ mode_pulse;
    if (confirm_pulse) begin
      case (state_q)
        ENTER_A: operand1_d = sw;
        ENTER_B: begin
          operand2_d   = sw;
          op_d         = op_t'(opsel);
          calc_start_d = 1'b1;
        end
        SHOW: begin
          operand1_d = '0;
          operand2_d = '0;
          op_d       = OP_ADD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand1_q   <= '0;
      operand2_q   <= '0;
      op_q         <= OP_ADD;
      calc_start_q <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      operand1_q   <= operand1_d;
      operand2_q   <= operand2_d;
      op_q         <= op_d;
      calc_start_q <= calc_start_d;
      mode_q       <= mode_d;
    end
  end

  assign disp.operand1           = operand1_q;
  assign disp.operand2           = operand2_q;
  assign disp.op                 = op_q;
  assign disp.confirmed_operand1 = conf1;
  assign disp.confirmed_operand2 = conf2;
  assign disp.calc_start         = calc_start_q;
  assign disp.mode               = mode_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// tb/tb_calc_input_sequencer.sv - scoreboard bench for calc_input_sequencer
module tb_calc_input_sequencer;
  import calc_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       BTNC, BTND;
  logic [3:0] sw;
  logic [1:0] opsel;

  calc_input_sequencer_if bus();

  calc_input_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .BTNC  (BTNC),
    .BTND  (BTND),
    .sw    (sw),
    .opsel (opsel),
    .disp  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] o1;
    logic [3:0] o2;
    logic [1:0] op;
    logic       c1;
    logic       c2;
    logic       st;
    logic       md;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    tests = 0;
  int    fails = 0;
  int    edge_cnt = 0;
  int    e;
  snap_t now_s;
  snap_t prev_s = '0;

  assign now_s = {bus.operand1, bus.operand2, bus.op, bus.confirmed_operand1,
                  bus.confirmed_operand2, bus.calc_start, bus.mode};

  function automatic snap_t mk(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                               input logic c1, input logic c2, input logic st, input logic md);
    mk = {a, b, o, c1, c2, st, md};
  endfunction

  task automatic expect_at(input snap_t s, input int cyc);
    exp_t x;
    x.s   = s;
    x.cyc = cyc;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input snap_t got, input snap_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Monitor: every change of the output bundle must match the next scoreboard entry and edge.
  always @(negedge clk) begin
    if (now_s !== prev_s) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %h at edge %0d, expected no change", now_s, edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (now_s !== mon_e.s || edge_cnt != mon_e.cyc) begin
          fails++;
          $display("FAIL output_change: got %h at edge %0d, expected %h at edge %0d",
                   now_s, edge_cnt, mon_e.s, mon_e.cyc);
        end
      end
    end
    prev_s = now_s;
  end

  task automatic btn_down(input logic c, input logic d, output int ed);
    @(negedge clk);
    if (c) BTNC = 1'b1;
    if (d) BTND = 1'b1;
    ed = edge_cnt;
  endtask

  task automatic btn_up();
    repeat (10) @(negedge clk);
    BTNC = 1'b0;
    BTND = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    BTNC  = 1'b0;
    BTND  = 1'b0;
    sw    = 4'h0;
    opsel = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_state", now_s, '0);
    reset = 1'b0;

    // Clean entry of A, then B with operator 2
    sw = 4'hA;
    btn_down(1'b1, 1'b0, e);
    expect_at(mk(4'hA, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), e + 7);
    btn_up();
    sw = 4'h3; opsel = 2'd2;
    btn_down(1'b1, 1'b0, e);
    expect_at(mk(4'hA, 4'h3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0), e + 7);
    expect_at(mk(4'hA, 4'h3, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0), e + 8);
    btn_up();

    // Mode toggle in SHOW, then wrap keeps mode
    btn_down(1'b0, 1'b1, e);
    expect_at(mk(4'hA, 4'h3, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1), e + 7);
    btn_up();
    btn_down(1'b1, 1'b0, e);
    expect_at(mk(4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), e + 7);
    btn_up();
    btn_down(1'b0, 1'b1, e);
    expect_at(mk(4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), e + 7);
    btn_up();
    btn_down(1'b0, 1'b1, e);
    expect_at(mk(4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), e + 7);
    btn_up();

    // Simultaneous confirm and mode press
    sw = 4'h5;
    btn_down(1'b1, 1'b1, e);
    expect_at(mk(4'h5, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), e + 7);
    btn_up();

    // Bouncing confirm: 2-cycle levels for 20 cycles, then settle high
    sw = 4'h6; opsel = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      BTNC = (i % 2 == 0);
      @(negedge clk);
    end
    btn_down(1'b1, 1'b0, e);
    expect_at(mk(4'h5, 4'h6, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0), e + 7);
    expect_at(mk(4'h5, 4'h6, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0), e + 8);
    btn_up();

    // Switch activity without any press
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      sw    = 4'(i * 7);
      opsel = 2'(i);
    end
    check("switches_no_press", now_s, mk(4'h5, 4'h6, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0));

    // Reach ENTER_B with operand1 = A and mode = 1, then reset mid-entry
    btn_down(1'b1, 1'b0, e);
    expect_at(mk(4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), e + 7);
    btn_up();
    sw = 4'hA;
    btn_down(1'b1, 1'b0, e);
    expect_at(mk(4'hA, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), e + 7);
    btn_up();
    btn_down(1'b0, 1'b1, e);
    expect_at(mk(4'hA, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1), e + 7);
    btn_up();

    @(negedge clk);
    e = edge_cnt;
    #2 reset = 1'b1;
    #1 check("reset_async", now_s, '0);
    expect_at('0, e + 1);
    sw   = 4'hC;
    BTNC = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e = edge_cnt;
    expect_at(mk(4'hC, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), e + 7);
    repeat (12) @(negedge clk);
    BTNC = 1'b0;
    repeat (10) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_input_sequencer.md
# calc_input_sequencer

Front-end input controller for the calculator. Conditions the raw board buttons and switches and sequences operand entry. Produces the `confirmed_operand1`, `confirmed_operand2`, `mode`, latched operand and start signals consumed by `display_control` and the ALU. It is the producing end of the display/entry interface: everything `display_control` reads as a level, this block generates cleanly from bouncy physical inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz); number of consecutive stable cycles before a button level is accepted; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `BTNC`  in  1  raw confirm button, asynchronous.
- `BTND`  in  1  raw display-mode toggle button, asynchronous.
- `sw`  in  4  operand switches, quasi-static.
- `opsel`  in  2  operator switches, quasi-static.
- `operand1`  out  4  latched first operand.
- `operand2`  out  4  latched second operand.
- `op`  out  2  latched operator.
- `confirmed_operand1`  out  1  high once operand1 is latched.
- `confirmed_operand2`  out  1  high once operand2 is latched.
- `calc_start`  out  1  one-cycle pulse when both operands are valid.
- `mode`  out  1  display radix: 0 = decimal, 1 = hexadecimal.

## Operation
- Each button path:
  - 2-flop synchronizer.
  - Debouncer holding the accepted level `deb` (reset 0) and counter `cnt` (reset 0).
  - Each edge where sync output ≠ `deb`: `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and the inputs still differ: `deb` takes the new level and `cnt` clears.
  - Any edge where sync output == `deb` clears `cnt`.
  - Press pulse = `deb & ~deb_q`, where `deb_q` is `deb` delayed one cycle. The pulse is exactly one cycle wide. Release produces no pulse.
- FSM states (in `calc_pkg`): `ENTER_A`, `ENTER_B`, `SHOW`.
  - `ENTER_A`:
    - `confirmed_operand1` = 0, `confirmed_operand2` = 0.
    - Confirm pulse: `operand1 <= sw`, go to `ENTER_B`.
  - `ENTER_B`:
    - `confirmed_operand1` = 1, `confirmed_operand2` = 0.
    - Confirm pulse: `operand2 <= sw`, `op <= opsel`, `calc_start <= 1` for one cycle, go to `SHOW`.
  - `SHOW`:
    - Both confirmed flags = 1.
    - Confirm pulse: `operand1`, `operand2` and `op` clear to 0, go to `ENTER_A`.
  - Confirm flags are decoded from the state register, so they are glitch-free.
- Mode:
  - A BTND press pulse toggles `mode` in any state.
  - `mode` is independent of the FSM and is not cleared on returning to `ENTER_A`.
- Simultaneous BTNC and BTND pulses in the same cycle: both take effect.
- Reset values (asynchronous): state `ENTER_A`, all operands/`op` 0, both confirmed flags 0, `calc_start` 0, `mode` 0, synchronizers, `deb`, `deb_q` and `cnt` all 0.
- A reset asserted mid-entry discards latched operands immediately. No pulse is generated after reset deasserts while a button is still held until `DEBOUNCE_CYCLES` have elapsed (`deb` starts at 0, so a held button registers as a fresh press).
- `sw` and `opsel` are sampled only on the confirm edge. Changes at other times have no effect on outputs.

## Timing
- Raw button rises before edge k and is held:
  - `deb` flips at edge k+1+`DEBOUNCE_CYCLES`.
  - Press pulse is high in the following cycle.
  - FSM/`mode` update at edge k+2+`DEBOUNCE_CYCLES`.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles (after sync) yields no pulse and no state change.
- `calc_start` is high for exactly the cycle after the `ENTER_B`→`SHOW` transition edge, coincident with `confirmed_operand2` first reading 1.
- Holding a button indefinitely produces exactly one pulse.

## Structure
- `calc_pkg`: `entry_state_t` enum (`ENTER_A`, `ENTER_B`, `SHOW`), `op_t` 2-bit operator typedef (ADD, SUB, MUL, DIV encodings), operand width constant `OPW = 4`.
- Sub-module `button_debouncer` (synchronizer + debounce counter + edge pulse), parameterized by `DEBOUNCE_CYCLES`, instantiated twice. The counter width is derived with `$clog2`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Clean entry: `sw`=0xA, press BTNC, release; `sw`=0x3, `opsel`=2, press BTNC → `operand1`=0xA, `operand2`=0x3, `op`=2, flags 1/1, single-cycle `calc_start` exactly 6 edges after the second press.
- Bounce: BTNC toggles every 2 cycles for 20 cycles, then settles high → exactly one state advance, occurring 6 edges after settling.
- Wrap: from `SHOW`, press BTNC → state `ENTER_A`, flags 0/0, operands 0, `mode` unchanged.
- Mode: three BTND presses → `mode` sequence 1, 0, 1. A simultaneous BTNC+BTND press in `ENTER_A` both latches `operand1` and toggles `mode`.
- Reset mid-entry: in `ENTER_B` with `operand1`=0xA, assert `reset` asynchronously → all outputs 0 the same instant. Releasing `reset` with BTNC held → one advance only after 6 edges.
- Switch changes without a press → no output change for 50 cycles.
